// File: rtl/control_cruce.sv
// Pedestrian crossing controller: vehicle green / amber / all-red, pedestrian walk,
// then clearance. A latched pedestrian request ends the minimum green.
module control_cruce #(
   parameter int unsigned T_VERDE_MIN = 8,
   parameter int unsigned T_AMARILLO  = 3,
   parameter int unsigned T_ROJO      = 2,
   parameter int unsigned T_PEATON    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       paso,
   output logic       veh_roja,
   output logic       veh_amarilla,
   output logic       veh_verde,
   output logic       pea_roja,
   output logic       pea_verde,
   output logic       espera,
   output logic [2:0] estado
);

   // state     | meaning
   // VERDE     | vehicles go; waits for min green plus a pending request
   // AMARILLO  | vehicle amber
   // TODO_ROJO | all-red clearance before pedestrians walk
   // PEATON    | pedestrians walk; pending request is consumed on entry
   // DESPEJE   | all-red clearance after pedestrians
   typedef enum logic [2:0] {
      VERDE     = 3'd0,
      AMARILLO  = 3'd1,
      TODO_ROJO = 3'd2,
      PEATON    = 3'd3,
      DESPEJE   = 3'd4
   } state_t;

   localparam logic [15:0] VERDE_LAST    = 16'(T_VERDE_MIN - 1);
   localparam logic [15:0] AMARILLO_LAST = 16'(T_AMARILLO - 1);
   localparam logic [15:0] ROJO_LAST     = 16'(T_ROJO - 1);
   localparam logic [15:0] PEATON_LAST   = 16'(T_PEATON - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        espera_q, espera_d;
   logic        entra_peaton;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= VERDE;
         cnt_q    <= '0;
         espera_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         espera_q <= espera_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      case (state_q)
         VERDE: begin
            if (cnt_q == VERDE_LAST) begin
               cnt_d = cnt_q;
               if (espera_q) begin
                  state_d = AMARILLO;
                  cnt_d   = '0;
               end
            end
         end
         AMARILLO: begin
            if (cnt_q == AMARILLO_LAST) begin
               state_d = TODO_ROJO;
               cnt_d   = '0;
            end
         end
         TODO_ROJO: begin
            if (cnt_q == ROJO_LAST) begin
               state_d = PEATON;
               cnt_d   = '0;
            end
         end
         PEATON: begin
            if (cnt_q == PEATON_LAST) begin
               state_d = DESPEJE;
               cnt_d   = '0;
            end
         end
         DESPEJE: begin
            if (cnt_q == ROJO_LAST) begin
               state_d = VERDE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = VERDE;
            cnt_d   = '0;
         end
      endcase
   end

   // A press on the very edge that starts the walk phase survives it.
   assign entra_peaton = (state_q == TODO_ROJO) && (state_d == PEATON);
   assign espera_d     = paso | (espera_q & ~entra_peaton);

   always_comb begin
      veh_roja     = 1'b0;
      veh_amarilla = 1'b0;
      veh_verde    = 1'b0;
      pea_roja     = 1'b0;
      pea_verde    = 1'b0;
      case (state_q)
         VERDE: begin
            veh_verde = 1'b1;
            pea_roja  = 1'b1;
         end
         AMARILLO: begin
            veh_amarilla = 1'b1;
            pea_roja     = 1'b1;
         end
         TODO_ROJO: begin
            veh_roja = 1'b1;
            pea_roja = 1'b1;
         end
         PEATON: begin
            veh_roja  = 1'b1;
            pea_verde = 1'b1;
         end
         DESPEJE: begin
            veh_roja = 1'b1;
            pea_roja = 1'b1;
         end
         default: begin
            veh_roja = 1'b1;
            pea_roja = 1'b1;
         end
      endcase
   end

   assign espera = espera_q;
   assign estado = state_q;

endmodule

// File: doc/control_cruce.md
CONTROL_CRUCE -- requirements
Module: control_cruce

Interface
REQ-001 Parameter T_VERDE_MIN, default 8, minimum vehicle-green duration in clk cycles, legal range 1..65535.
REQ-002 Parameter T_AMARILLO, default 3, vehicle-amber duration in clk cycles, legal range 1..65535.
REQ-003 Parameter T_ROJO, default 2, all-red clearance duration in clk cycles, legal range 1..65535.
REQ-004 Parameter T_PEATON, default 5, pedestrian-green duration in clk cycles, legal range 1..65535.
REQ-005 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 paso  input  1  pedestrian request button, synchronous to clk, level-sampled on every rising edge.
REQ-008 veh_roja, veh_amarilla, veh_verde  output  1 each  vehicle lamp drives.
REQ-009 pea_roja, pea_verde  output  1 each  pedestrian lamp drives.
REQ-010 espera  output  1  pedestrian request pending (registered latch).
REQ-011 estado  output  3  current state code.

Function
REQ-012 The block SHALL have states VERDE=0, AMARILLO=1, TODO_ROJO=2, PEATON=3, DESPEJE=4 held in a 3-bit register driven directly onto estado.
REQ-013 The block SHALL contain a 16-bit cycle counter cnt that is cleared on every state transition and increments each cycle otherwise.
REQ-014 In VERDE, cnt SHALL saturate at T_VERDE_MIN-1.
REQ-015 VERDE SHALL transition to AMARILLO on an edge where cnt==T_VERDE_MIN-1 and espera==1; otherwise it SHALL remain in VERDE indefinitely.
REQ-016 AMARILLO->TODO_ROJO, TODO_ROJO->PEATON, PEATON->DESPEJE and DESPEJE->VERDE SHALL each occur on the edge where cnt==T-1 for that state's parameter, so each state lasts exactly T cycles.
REQ-017 espera SHALL be set on any edge sampling paso==1.
REQ-018 espera SHALL be cleared on the edge entering PEATON unless paso==1 on that same edge, in which case set wins.
REQ-019 Presses during AMARILLO or TODO_ROJO SHALL be absorbed by the service in progress.
REQ-020 Presses during PEATON or DESPEJE SHALL leave espera=1, so the request is served after the next full minimum green.
REQ-021 Lamp outputs SHALL be Moore-decoded from estado as follows:
- VERDE: veh_verde=1, pea_roja=1
- AMARILLO: veh_amarilla=1, pea_roja=1
- TODO_ROJO: veh_roja=1, pea_roja=1
- PEATON: veh_roja=1, pea_verde=1
- DESPEJE: veh_roja=1, pea_roja=1
REQ-022 Every lamp not listed for a state in REQ-021 SHALL be 0.
REQ-023 At no time SHALL more than one vehicle lamp be 1, nor both pedestrian lamps be 1.
REQ-024 pea_verde SHALL NOT be 1 in the same cycle as veh_verde or veh_amarilla.
REQ-025 Illegal codes 5..7 SHALL drive veh_roja=1 and pea_roja=1 only, and SHALL return to VERDE with cnt=0 on the next edge.
REQ-026 Press-to-amber latency from VERDE with cnt saturated SHALL be 2 edges: paso sampled at edge k, espera=1 after edge k, AMARILLO after edge k+1.

Reset
REQ-027 While rst==1, the block SHALL force estado=VERDE, cnt=0 and espera=0 immediately, independent of clk.
REQ-028 While rst==1, the outputs SHALL read veh_verde=1, pea_roja=1 and all other lamps 0.
REQ-029 Reset asserted in any state, including mid-PEATON, SHALL abandon the cycle and discard any pending request.
REQ-030 After rst deasserts, the first edge SHALL count cnt 0->1 in VERDE.

Verification (default parameters)
REQ-031 Release reset, hold paso=0 for 100 cycles -> estado=0, veh_verde=1, pea_roja=1 and espera=0 throughout.
REQ-032 Pulse paso for 1 cycle at cycle 20 -> espera=1 next cycle, then the following sequence in exact cycle counts:
- AMARILLO 3 cycles
- TODO_ROJO 2 cycles
- PEATON 5 cycles, with pea_verde=1 and espera=0
- DESPEJE 2 cycles
- return to VERDE
REQ-033 Pulse paso at edge 1 after reset -> VERDE lasts 8 cycles total, then AMARILLO begins after edge 8.
REQ-034 Pulse paso during PEATON -> espera stays 1 through DESPEJE, and the next AMARILLO starts exactly 8 cycles after re-entering VERDE.
REQ-035 Assert rst asynchronously mid-PEATON -> outputs show veh_verde=1, pea_verde=0 and espera=0 before the next edge.
REQ-036 Hold paso=1 continuously -> estado cycles with period 20 (8+3+2+5+2), and the REQ-023/REQ-024 lamp-exclusion checks hold every cycle.
